// File: rtl/tb_mem_arbiter.sv
// Round-robin arbiter for two requesters onto one memory port; grant to ready pulse is 3 cycles with a 1-cycle-latency memory.
// Backpressure: requests wait while busy, the memory stalls via mem_data_ready, and the watchdog aborts after timeout_cycles.
module tb_mem_arbiter #(
    parameter int addr_width     = 16,
    parameter int timeout_cycles = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rq0_req,
    input  logic                  rq1_req,
    input  logic [addr_width-1:0] rq0_addr,
    input  logic [addr_width-1:0] rq1_addr,
    input  logic [7:0]            rq0_wdata_8,
    input  logic [7:0]            rq1_wdata_8,
    input  logic [15:0]           rq0_wdata_16,
    input  logic [15:0]           rq1_wdata_16,
    input  logic                  rq0_acc_sz,
    input  logic                  rq1_acc_sz,
    input  logic                  rq0_we,
    input  logic                  rq1_we,
    output logic                  rq0_ready,
    output logic                  rq1_ready,
    output logic                  rq0_err,
    output logic                  rq1_err,
    output logic [7:0]            rd_data_8,
    output logic [15:0]           rd_data_16,
    output logic                  busy,
    output logic                  grant_id,
    output logic                  mem_req_rdwr,
    output logic [addr_width-1:0] mem_addr,
    output logic [7:0]            mem_wdata_8,
    output logic [15:0]           mem_wdata_16,
    output logic                  mem_acc_sz,
    output logic                  mem_we_8,
    output logic                  mem_we_16,
    input  logic [7:0]            mem_rdata_8,
    input  logic [15:0]           mem_rdata_16,
    input  logic                  mem_data_ready
);

    localparam int               CNT_W     = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(timeout_cycles - 1);
    localparam logic             ACC_SZ_16 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rq0_ready_q, rq0_ready_d;
    logic                  rq1_ready_q, rq1_ready_d;
    logic                  rq0_err_q, rq0_err_d;
    logic                  rq1_err_q, rq1_err_d;
    logic [7:0]            rd_data_8_q, rd_data_8_d;
    logic [15:0]           rd_data_16_q, rd_data_16_d;
    logic                  busy_q, busy_d;
    logic                  grant_id_q, grant_id_d;
    logic                  mem_req_rdwr_q, mem_req_rdwr_d;
    logic [addr_width-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_8_q, mem_wdata_8_d;
    logic [15:0]           mem_wdata_16_q, mem_wdata_16_d;
    logic                  mem_acc_sz_q, mem_acc_sz_d;
    logic                  mem_we_8_q, mem_we_8_d;
    logic                  mem_we_16_q, mem_we_16_d;

    logic                  gnt_vld, gnt_sel;
    logic [addr_width-1:0] sel_addr;
    logic [7:0]            sel_wdata_8;
    logic [15:0]           sel_wdata_16;
    logic                  sel_acc_sz, sel_we;
    logic                  timeout_hit, acc_done, was_read;

    // On a tie the requester that was not served last wins.
    always_comb begin
        gnt_vld      = rq0_req | rq1_req;
        gnt_sel      = (rq0_req && rq1_req) ? ~last_grant_q : rq1_req;
        sel_addr     = gnt_sel ? rq1_addr     : rq0_addr;
        sel_wdata_8  = gnt_sel ? rq1_wdata_8  : rq0_wdata_8;
        sel_wdata_16 = gnt_sel ? rq1_wdata_16 : rq0_wdata_16;
        sel_acc_sz   = gnt_sel ? rq1_acc_sz   : rq0_acc_sz;
        sel_we       = gnt_sel ? rq1_we       : rq0_we;
        timeout_hit  = (cnt_q == CNT_LAST);
        acc_done     = mem_data_ready || timeout_hit;
        was_read     = !(mem_we_8_q || mem_we_16_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (gnt_vld) state_d = ST_ACCESS;
            ST_ACCESS: if (acc_done) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_grant_d   = last_grant_q;
        cnt_d          = cnt_q;
        rq0_ready_d    = 1'b0;
        rq1_ready_d    = 1'b0;
        rq0_err_d      = 1'b0;
        rq1_err_d      = 1'b0;
        rd_data_8_d    = rd_data_8_q;
        rd_data_16_d   = rd_data_16_q;
        busy_d         = busy_q;
        grant_id_d     = grant_id_q;
        mem_req_rdwr_d = mem_req_rdwr_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_8_d  = mem_wdata_8_q;
        mem_wdata_16_d = mem_wdata_16_q;
        mem_acc_sz_d   = mem_acc_sz_q;
        mem_we_8_d     = mem_we_8_q;
        mem_we_16_d    = mem_we_16_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    mem_addr_d     = sel_addr;
                    mem_wdata_8_d  = sel_wdata_8;
                    mem_wdata_16_d = sel_wdata_16;
                    mem_acc_sz_d   = sel_acc_sz;
                    mem_we_8_d     = sel_we && (sel_acc_sz != ACC_SZ_16);
                    mem_we_16_d    = sel_we && (sel_acc_sz == ACC_SZ_16);
                    mem_req_rdwr_d = 1'b1;
                    grant_id_d     = gnt_sel;
                    last_grant_d   = gnt_sel;
                    cnt_d          = '0;
                    busy_d         = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (acc_done) begin
                    if (mem_data_ready && was_read) begin
                        if (mem_acc_sz_q == ACC_SZ_16) rd_data_16_d = mem_rdata_16;
                        else                           rd_data_8_d  = mem_rdata_8;
                    end
                    // Completion is reported in DONE, where the port drops so the memory sees a gap.
                    mem_req_rdwr_d = 1'b0;
                    mem_we_8_d     = 1'b0;
                    mem_we_16_d    = 1'b0;
                    rq0_ready_d    = ~grant_id_q;
                    rq1_ready_d    = grant_id_q;
                    rq0_err_d      = ~grant_id_q && !mem_data_ready;
                    rq1_err_d      = grant_id_q && !mem_data_ready;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q   <= 1'b1;
            cnt_q          <= '0;
            rq0_ready_q    <= 1'b0;
            rq1_ready_q    <= 1'b0;
            rq0_err_q      <= 1'b0;
            rq1_err_q      <= 1'b0;
            rd_data_8_q    <= '0;
            rd_data_16_q   <= '0;
            busy_q         <= 1'b0;
            grant_id_q     <= 1'b0;
            mem_req_rdwr_q <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_8_q  <= '0;
            mem_wdata_16_q <= '0;
            mem_acc_sz_q   <= 1'b0;
            mem_we_8_q     <= 1'b0;
            mem_we_16_q    <= 1'b0;
        end else begin
            last_grant_q   <= last_grant_d;
            cnt_q          <= cnt_d;
            rq0_ready_q    <= rq0_ready_d;
            rq1_ready_q    <= rq1_ready_d;
            rq0_err_q      <= rq0_err_d;
            rq1_err_q      <= rq1_err_d;
            rd_data_8_q    <= rd_data_8_d;
            rd_data_16_q   <= rd_data_16_d;
            busy_q         <= busy_d;
            grant_id_q     <= grant_id_d;
            mem_req_rdwr_q <= mem_req_rdwr_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_8_q  <= mem_wdata_8_d;
            mem_wdata_16_q <= mem_wdata_16_d;
            mem_acc_sz_q   <= mem_acc_sz_d;
            mem_we_8_q     <= mem_we_8_d;
            mem_we_16_q    <= mem_we_16_d;
        end
    end

    assign rq0_ready    = rq0_ready_q;
    assign rq1_ready    = rq1_ready_q;
    assign rq0_err      = rq0_err_q;
    assign rq1_err      = rq1_err_q;
    assign rd_data_8    = rd_data_8_q;
    assign rd_data_16   = rd_data_16_q;
    assign busy         = busy_q;
    assign grant_id     = grant_id_q;
    assign mem_req_rdwr = mem_req_rdwr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata_8  = mem_wdata_8_q;
    assign mem_wdata_16 = mem_wdata_16_q;
    assign mem_acc_sz   = mem_acc_sz_q;
    assign mem_we_8     = mem_we_8_q;
    assign mem_we_16    = mem_we_16_q;

endmodule
